// File: rtl/tdm_mux_8x1.sv
// tdm_mux_8x1: merges 8 producer channels onto one beat stream tagged
// with a 3-bit select code, using per-channel holds and a round-robin arbiter.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_data         8 x DATA_W; channel i at [i*DATA_W +: DATA_W]
//   in_valid/ready  per-channel handshake (ready from registered state only)
//   out_data/sel    registered beat data and channel number {s2,s1,s0}
//   out_valid/ready registered output handshake
//   pending         number of full hold registers (0..8), registered
module tdm_mux_8x1 #(
    parameter int DATA_W = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [8*DATA_W-1:0] in_data,
    input  logic [7:0]          in_valid,
    output logic [7:0]          in_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [2:0]          out_sel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          pending
);

    logic              r_rdy_en;
    logic [7:0]        r_hold_vld;
    logic [DATA_W-1:0] r_hold_data [8];
    logic [2:0]        r_rr_ptr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [2:0]        r_out_sel;
    logic [3:0]        r_pending;

    logic [7:0] w_cap;
    logic [7:0] w_clr;
    logic [7:0] w_hold_nxt;
    logic       w_load;
    logic       w_gnt_vld;
    logic [2:0] w_gnt;
    logic [3:0] w_pending_nxt;

    // A full hold register blocks its channel; a granted hold reopens
    // only in the following cycle, so clear and refill never collide.
    assign in_ready = {8{r_rdy_en}} & ~r_hold_vld;
    assign w_cap    = in_valid & in_ready;
    assign w_load   = ~r_out_valid | out_ready;

    // Scan downward so the last hit, i.e. the nearest channel at or
    // after the pointer, wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = r_rr_ptr;
        for (int k = 7; k >= 0; k--) begin
            if (r_hold_vld[r_rr_ptr + 3'(k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = r_rr_ptr + 3'(k);
            end
        end
    end

    always_comb begin
        w_clr = 8'b0;
        if (w_load && w_gnt_vld) begin
            w_clr = 8'b1 << w_gnt;
        end
        w_hold_nxt    = (r_hold_vld & ~w_clr) | w_cap;
        w_pending_nxt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_pending_nxt = w_pending_nxt + {3'b000, w_hold_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en    <= 1'b0;
            r_hold_vld  <= 8'b0;
            r_rr_ptr    <= 3'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= 3'd0;
            r_pending   <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                r_hold_data[i] <= '0;
            end
        end else begin
            r_rdy_en   <= 1'b1;
            r_hold_vld <= w_hold_nxt;
            r_pending  <= w_pending_nxt;
            for (int i = 0; i < 8; i++) begin
                if (w_cap[i]) begin
                    r_hold_data[i] <= in_data[i*DATA_W +: DATA_W];
                end
            end
            if (w_load) begin
                if (w_gnt_vld) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_hold_data[w_gnt];
                    r_out_sel   <= w_gnt;
                    r_rr_ptr    <= w_gnt + 3'd1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign pending   = r_pending;

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// tb_tdm_mux_8x1: scoreboard bench for tdm_mux_8x1 (DATA_W = 1).
// Expected beats {sel,data} are queued at drive time, popped on transfer.
module tb_tdm_mux_8x1;

    typedef logic [3:0] beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic [7:0] in_valid = 8'h00;
    logic [7:0] in_ready;
    logic [0:0] out_data;
    logic [2:0] out_sel;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] pending;

    beat_t q[$];
    int    nvec = 0;
    int    nerr = 0;

    tdm_mux_8x1 #(.DATA_W(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nvec++;
        if ({out_valid, pending, in_ready} !== 13'h0) begin
            nerr++;
            $display("FAIL rst_state got v=%b p=%0d rdy=%h exp 0/0/00",
                     out_valid, pending, in_ready);
        end
        nvec++;
        if ({out_sel, out_data} !== 4'h0) begin
            nerr++;
            $display("FAIL rst_out got sel=%0d d=%b exp 0/0", out_sel, out_data);
        end
        rst_n = 1'b1;
        #1;
        nvec++;
        if (in_ready !== 8'h00) begin
            nerr++;
            $display("FAIL rdy_first got %h exp 00", in_ready);
        end
        @(negedge clk);
        nvec++;
        if (in_ready !== 8'hFF) begin
            nerr++;
            $display("FAIL rdy_second got %h exp ff", in_ready);
        end
        repeat (2) @(negedge clk);
        nvec++;
        if (out_valid !== 1'b0 || pending !== 4'd0) begin
            nerr++;
            $display("FAIL idle got v=%b p=%0d exp 0/0", out_valid, pending);
        end
    endtask

    task automatic test_all8();
        beat_t e;
        in_data  = 8'hAA;
        in_valid = 8'hFF;
        for (int i = 0; i < 8; i++) q.push_back({3'(i), in_data[i]});
        @(negedge clk);
        in_valid = 8'h00;
        nvec++;
        if (pending !== 4'd8 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL all8_cap got p=%0d v=%b exp 8/0", pending, out_valid);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            nvec++;
            if (out_valid !== 1'b1) begin
                nerr++;
                $display("FAIL all8_beat%0d got v=%b exp 1", k, out_valid);
            end else if (q.size() > 0) begin
                e = q.pop_front();
                if ({out_sel, out_data} !== e) begin
                    nerr++;
                    $display("FAIL all8_beat%0d got %h exp %h", k, {out_sel, out_data}, e);
                end
            end
            nvec++;
            if (pending !== 4'(8 - k)) begin
                nerr++;
                $display("FAIL all8_pend%0d got %0d exp %0d", k, pending, 8 - k);
            end
        end
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            nerr++;
            $display("FAIL all8_end got v=%b left=%0d exp 0/0", out_valid, q.size());
            q.delete();
        end
    endtask

    task automatic test_single();
        beat_t e;
        in_data  = 8'h20;
        in_valid = 8'h20;
        q.push_back({3'd5, 1'b1});
        @(negedge clk);
        in_valid = 8'h00;
        nvec++;
        if (in_ready[5] !== 1'b0 || out_valid !== 1'b0 || pending !== 4'd1) begin
            nerr++;
            $display("FAIL single_cap got r5=%b v=%b p=%0d exp 0/0/1",
                     in_ready[5], out_valid, pending);
        end
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL single_beat got v=%b exp 1", out_valid);
        end else begin
            e = q.pop_front();
            if ({out_sel, out_data} !== e) begin
                nerr++;
                $display("FAIL single_beat got %h exp %h", {out_sel, out_data}, e);
            end
        end
        nvec++;
        if (in_ready[5] !== 1'b1 || pending !== 4'd0) begin
            nerr++;
            $display("FAIL single_rel got r5=%b p=%0d exp 1/0", in_ready[5], pending);
        end
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            nerr++;
            $display("FAIL single_once got v=%b left=%0d exp 0/0", out_valid, q.size());
            q.delete();
        end
    endtask

    task automatic test_rr_wrap();
        beat_t e;
        int    popped = 0;
        int    cyc = 0;
        in_data  = 8'h04;
        in_valid = 8'h44;
        for (int i = 0; i < 3; i++) begin
            q.push_back({3'd6, 1'b0});
            q.push_back({3'd2, 1'b1});
        end
        while (q.size() > 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready) begin
                e = q.pop_front();
                popped++;
                nvec++;
                if ({out_sel, out_data} !== e) begin
                    nerr++;
                    $display("FAIL rr_beat%0d got %h exp %h", popped, {out_sel, out_data}, e);
                end
                if (popped == 5) in_valid = 8'h00;
            end
        end
        in_valid = 8'h00;
        nvec++;
        if (q.size() != 0 || cyc != 7) begin
            nerr++;
            $display("FAIL rr_rate got cyc=%0d left=%0d exp 7/0", cyc, q.size());
            q.delete();
        end
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b0 || pending !== 4'd0) begin
            nerr++;
            $display("FAIL rr_end got v=%b p=%0d exp 0/0", out_valid, pending);
        end
    endtask

    task automatic test_back_pressure();
        beat_t e;
        out_ready = 1'b0;
        in_data   = 8'h28;
        in_valid  = 8'h2A;
        q.push_back({3'd3, 1'b1});
        q.push_back({3'd5, 1'b1});
        q.push_back({3'd1, 1'b0});
        @(negedge clk);
        in_valid = 8'h00;
        nvec++;
        if (pending !== 4'd3) begin
            nerr++;
            $display("FAIL bp_cap got p=%0d exp 3", pending);
        end
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            nvec++;
            if (out_valid !== 1'b1 || {out_sel, out_data} !== q[0] ||
                pending !== 4'd2 || in_ready !== 8'hDD) begin
                nerr++;
                $display("FAIL bp_stall%0d got v=%b b=%h p=%0d r=%h exp 1/%h/2/dd",
                         s, out_valid, {out_sel, out_data}, pending, in_ready, q[0]);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            nvec++;
            if (out_valid !== 1'b1) begin
                nerr++;
                $display("FAIL bp_beat%0d got v=%b exp 1", k, out_valid);
            end else begin
                e = q.pop_front();
                if ({out_sel, out_data} !== e) begin
                    nerr++;
                    $display("FAIL bp_beat%0d got %h exp %h", k, {out_sel, out_data}, e);
                end
            end
        end
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b0 || pending !== 4'd0 || q.size() != 0) begin
            nerr++;
            $display("FAIL bp_end got v=%b p=%0d left=%0d exp 0/0/0",
                     out_valid, pending, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_data   = 8'h00;
        in_valid  = 8'hD5;
        @(negedge clk);
        in_valid = 8'h00;
        nvec++;
        if (pending !== 4'd5) begin
            nerr++;
            $display("FAIL mid_cap got p=%0d exp 5", pending);
        end
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b1 || pending !== 4'd4 || out_sel !== 3'd2) begin
            nerr++;
            $display("FAIL mid_pre got v=%b p=%0d s=%0d exp 1/4/2",
                     out_valid, pending, out_sel);
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if (out_valid !== 1'b0 || pending !== 4'd0 || in_ready !== 8'h00) begin
            nerr++;
            $display("FAIL mid_async got v=%b p=%0d r=%h exp 0/0/00",
                     out_valid, pending, in_ready);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            nvec++;
            if (out_valid !== 1'b0 || pending !== 4'd0) begin
                nerr++;
                $display("FAIL mid_stale%0d got v=%b p=%0d exp 0/0", c, out_valid, pending);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all8();
        test_single();
        test_rr_wrap();
        test_back_pressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
